// File: rtl/sblk_act_sched.sv
// Activation-feed scheduler for one sblk row: latches a row instruction, then streams
// N_TILE*n_tn*n_tp beats from a 1-cycle-latency buffer per row request, n_ln*n_lp times.
module sblk_act_sched #(
  parameter int N_TILE      = 4,
  parameter int WID_N_TILE  = $clog2(N_TILE),
  parameter int WID_ACT     = 16,
  parameter int WID_ACTADDR = 6,
  parameter int WID_INST_TN = 3,
  parameter int WID_INST_TM = 3,
  parameter int WID_INST_TP = 3,
  parameter int WID_INST_LN = 3,
  parameter int WID_INST_LP = 3,
  parameter int WID_INST    = WID_INST_TN + WID_INST_TM + WID_INST_TP + WID_INST_LN + WID_INST_LP
) (
  input  logic                             clk_l,
  input  logic                             rst_n,
  input  logic [WID_INST-1:0]              inst_data,
  input  logic                             inst_en,
  input  logic                             act_data_in_req,
  output logic                             buf_ren,
  output logic [WID_N_TILE+WID_ACTADDR-1:0] buf_raddr,
  input  logic [2*WID_ACT-1:0]             buf_rdata,
  output logic                             act_data_out_vld,
  output logic [2*WID_ACT-1:0]             act_data_out,
  output logic                             busy,
  output logic                             done,
  output logic                             inst_err
);

  localparam int WID_BURST = WID_INST_LN + WID_INST_LP;
  localparam int OFS_TM    = WID_INST_TN;
  localparam int OFS_TP    = OFS_TM + WID_INST_TM;
  localparam int OFS_LN    = OFS_TP + WID_INST_TP;
  localparam int OFS_LP    = OFS_LN + WID_INST_LN;
  localparam logic [WID_N_TILE-1:0] TILE_LAST = WID_N_TILE'(N_TILE - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_REQ, S_BURST, S_DRAIN} state_t;
  state_t state_reg, state_next;

  logic [WID_INST_TN-1:0] tn_in, tn_reg;
  logic [WID_INST_TM-1:0] tm_in;
  logic [WID_INST_TP-1:0] tp_in, tp_reg;
  logic [WID_INST_LN-1:0] ln_in, ln_reg;
  logic [WID_INST_LP-1:0] lp_in, lp_reg;
  // Output-channel count travels with the instruction but the row owns that loop.
  logic [WID_INST_TM-1:0] tm_unused_reg;

  logic [WID_INST_TP-1:0] p_cnt_reg;
  logic [WID_INST_TN-1:0] n_cnt_reg;
  logic [WID_N_TILE-1:0]  tile_cnt_reg;
  logic [WID_BURST-1:0]   burst_cnt_reg;
  logic                   busy_reg, done_reg, inst_err_reg, vld_reg;

  logic                   fields_ok, accept;
  logic                   p_last, n_last, tile_last, last_beat, last_burst, done_next;
  logic [WID_BURST-1:0]   burst_total;
  logic [WID_ACTADDR-1:0] offset;

  assign tn_in = inst_data[WID_INST_TN-1:0];
  assign tm_in = inst_data[OFS_TM +: WID_INST_TM];
  assign tp_in = inst_data[OFS_TP +: WID_INST_TP];
  assign ln_in = inst_data[OFS_LN +: WID_INST_LN];
  assign lp_in = inst_data[OFS_LP +: WID_INST_LP];

  assign fields_ok = (tn_in != '0) && (tp_in != '0) && (ln_in != '0) && (lp_in != '0);
  // busy_reg is still high in the done cycle, so a strobe landing there is refused.
  assign accept    = inst_en && (state_reg == S_IDLE) && !busy_reg && fields_ok;

  assign p_last      = (p_cnt_reg == tp_reg - WID_INST_TP'(1));
  assign n_last      = (n_cnt_reg == tn_reg - WID_INST_TN'(1));
  assign tile_last   = (tile_cnt_reg == TILE_LAST);
  assign last_beat   = p_last && n_last && tile_last;
  assign burst_total = WID_BURST'(ln_reg) * WID_BURST'(lp_reg);
  assign last_burst  = ((burst_cnt_reg + WID_BURST'(1)) == burst_total);
  assign offset      = WID_ACTADDR'(n_cnt_reg) * WID_ACTADDR'(tp_reg) + WID_ACTADDR'(p_cnt_reg);

  assign buf_ren          = (state_reg == S_BURST);
  assign buf_raddr        = {tile_cnt_reg, offset};
  assign act_data_out_vld = vld_reg;
  assign act_data_out     = vld_reg ? buf_rdata : '0;
  assign busy             = busy_reg;
  assign done             = done_reg;
  assign inst_err         = inst_err_reg;

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    case (state_reg)
      S_IDLE:     if (accept) state_next = S_WAIT_REQ;
      S_WAIT_REQ: if (act_data_in_req) state_next = S_BURST;
      S_BURST:    if (last_beat) state_next = S_DRAIN;
      S_DRAIN: begin
        if (last_burst) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = S_WAIT_REQ;
        end
      end
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      tn_reg        <= '0;
      tm_unused_reg <= '0;
      tp_reg        <= '0;
      ln_reg        <= '0;
      lp_reg        <= '0;
      p_cnt_reg     <= '0;
      n_cnt_reg     <= '0;
      tile_cnt_reg  <= '0;
      burst_cnt_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      inst_err_reg  <= 1'b0;
      vld_reg       <= 1'b0;
    end else begin
      done_reg     <= done_next;
      busy_reg     <= (state_next != S_IDLE) || done_next;
      inst_err_reg <= inst_en && !accept;
      vld_reg      <= buf_ren;
      if (accept) begin
        tn_reg        <= tn_in;
        tm_unused_reg <= tm_in;
        tp_reg        <= tp_in;
        ln_reg        <= ln_in;
        lp_reg        <= lp_in;
      end
      // Counters wrap to zero on the last beat so the next burst starts clean.
      if (state_reg == S_BURST) begin
        if (p_last) begin
          p_cnt_reg <= '0;
          if (n_last) begin
            n_cnt_reg    <= '0;
            tile_cnt_reg <= tile_last ? '0 : tile_cnt_reg + WID_N_TILE'(1);
          end else begin
            n_cnt_reg <= n_cnt_reg + WID_INST_TN'(1);
          end
        end else begin
          p_cnt_reg <= p_cnt_reg + WID_INST_TP'(1);
        end
      end
      if (state_reg == S_DRAIN)
        burst_cnt_reg <= last_burst ? '0 : burst_cnt_reg + WID_BURST'(1);
    end
  end

endmodule
